pipelined_adder: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor with valid/ready handshakes on input and output. The WIDTH-bit operation is split into STAGES equal chunks. Each pipeline stage adds one chunk and registers the carry into the next stage. It is the multi-bit, registered successor to the single-bit full adder and is intended for datapaths that need throughput of one operation per cycle at high clock rates.

---
 rtl/pipelined_adder_if.sv | 27 ++
 rtl/pipelined_adder.sv | 126 ++++++++++++
 tb/tb_pipelined_adder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The slave modport is the adder's view; master is the producer/consumer side.
interface pipelined_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             c_in;
    logic             sub;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_a, in_b, c_in, sub, in_valid, out_ready,
        input  in_ready, sum, c_out, overflow, out_valid
    );

    modport slave (
        input  in_a, in_b, c_in, sub, in_valid, out_ready,
        output in_ready, sum, c_out, overflow, out_valid
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined two's-complement adder/subtractor: one CW-bit chunk per stage,
// carry registered between stages, global stall driven by the output register.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic               clk,
    input  logic               rst,
    pipelined_adder_if.slave   bus
);
    localparam int unsigned CW = WIDTH / STAGES;

    logic advance;

    // Index k holds the operands/partial result entering stage k.
    logic [WIDTH-1:0]  pipe_a [STAGES];
    logic [WIDTH-1:0]  pipe_b [STAGES];
    logic [WIDTH-1:0]  pipe_s [STAGES];
    logic [STAGES-1:0] pipe_c;
    logic [STAGES-1:0] pipe_v;

    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    assign advance      = !out_valid_q | bus.out_ready;
    assign bus.in_ready = advance;

    assign pipe_a[0] = bus.in_a;
    assign pipe_b[0] = bus.sub ? ~bus.in_b : bus.in_b;
    assign pipe_s[0] = '0;
    assign pipe_c[0] = bus.sub ? 1'b1 : bus.c_in;
    assign pipe_v[0] = bus.in_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CW-1:0]    chunk;
        logic             carry;
        logic [WIDTH-1:0] part;

        assign {carry, chunk} = {1'b0, pipe_a[k][k*CW +: CW]}
                              + {1'b0, pipe_b[k][k*CW +: CW]}
                              + {{CW{1'b0}}, pipe_c[k]};
        // Chunks above k are still zero, so OR-ing places this chunk in the partial sum.
        assign part = pipe_s[k] | (WIDTH'(chunk) << (k*CW));

        if (k < STAGES - 1) begin : g_reg
            logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
            logic             c_q, c_d, v_q, v_d;

            always_comb begin
                a_d = a_q;
                b_d = b_q;
                s_d = s_q;
                c_d = c_q;
                v_d = v_q;
                if (advance) begin
                    a_d = pipe_a[k];
                    b_d = pipe_b[k];
                    s_d = part;
                    c_d = carry;
                    v_d = pipe_v[k];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                    c_q <= 1'b0;
                    v_q <= 1'b0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                    s_q <= s_d;
                    c_q <= c_d;
                    v_q <= v_d;
                end
            end

            assign pipe_a[k+1] = a_q;
            assign pipe_b[k+1] = b_q;
            assign pipe_s[k+1] = s_q;
            assign pipe_c[k+1] = c_q;
            assign pipe_v[k+1] = v_q;
        end else begin : g_out
            logic msb_cin;

            // Carry into the MSB recovered from its sum bit and operand bits.
            assign msb_cin = part[WIDTH-1] ^ pipe_a[k][WIDTH-1] ^ pipe_b[k][WIDTH-1];

            always_comb begin
                sum_d       = sum_q;
                c_out_d     = c_out_q;
                ovf_d       = ovf_q;
                out_valid_d = out_valid_q;
                if (advance) begin
                    sum_d       = part;
                    c_out_d     = carry;
                    ovf_d       = msb_cin ^ carry;
                    out_valid_d = pipe_v[k];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            c_out_q     <= c_out_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
    assign bus.overflow  = ovf_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, STAGES=4): directed vectors,
// a stalled random stream against a queue-based reference model, and mid-flight reset.
module tb_pipelined_adder;
    localparam int unsigned W = 16;
    localparam int unsigned S = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(W)) bus ();

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: {overflow, c_out, sum} from signed/unsigned integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci, input logic sb);
        int          r;
        int unsigned u;
        logic        co;
        logic [W-1:0] s;
        if (sb) begin
            r  = int'($signed(a)) - int'($signed(b));
            co = (a >= b);
            s  = a - b;
        end else begin
            r  = int'($signed(a)) + int'($signed(b)) + int'({31'd0, ci});
            u  = 32'(a) + 32'(b) + 32'(ci);
            co = (u > 32'd65535);
            s  = u[W-1:0];
        end
        return {(r > 32767) || (r < -32768), co, s};
    endfunction

    // Scoreboard monitor: samples handshakes on the falling edge.
    logic [W+1:0] expq[$];
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_sum   = '0;
    int           drained    = 0;
    int           stall_cnt  = 0;

    always @(negedge clk) begin
        logic [W+1:0] e;
        if (rst) begin
            expq.delete();
            prev_stall = 1'b0;
        end else begin
            chk("in_ready_rule", 32'(bus.in_ready), 32'(!bus.out_valid | bus.out_ready));
            if (!bus.in_ready) stall_cnt++;
            if (prev_stall) begin
                chk("stall_hold_sum", 32'(bus.sum), 32'(prev_sum));
                chk("stall_hold_valid", 32'(bus.out_valid), 32'd1);
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("result_expected", 32'(expq.size() != 0), 32'd1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    chk("sb_sum", 32'(bus.sum), 32'(e[W-1:0]));
                    chk("sb_c_out", 32'(bus.c_out), 32'(e[W]));
                    chk("sb_overflow", 32'(bus.overflow), 32'(e[W+1]));
                end
                drained++;
            end
            if (bus.in_valid && bus.in_ready)
                expq.push_back(model(bus.in_a, bus.in_b, bus.c_in, bus.sub));
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_sum   = bus.sum;
        end
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         sb;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vt[8];

    task automatic apply_vec(input vec_t v, input string tag);
        int lat;
        @(posedge clk); #1;
        bus.in_a = v.a; bus.in_b = v.b; bus.c_in = v.ci; bus.sub = v.sb;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(S));
        chk({tag, "_sum"}, 32'(bus.sum), 32'(v.s));
        chk({tag, "_c_out"}, 32'(bus.c_out), 32'(v.co));
        chk({tag, "_overflow"}, 32'(bus.overflow), 32'(v.ov));
        @(posedge clk); #1;
        chk({tag, "_bubble_drop"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra[10];
        logic [W-1:0] rb[10];
        logic         rc[10];
        logic         rs[10];
        int           idx, cyc, d0, seen;
        logic         took;

        vt[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[2] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[3] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vt[5] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
        vt[6] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vt[7] = '{16'h0000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

        bus.in_a = '0; bus.in_b = '0; bus.c_in = 1'b0; bus.sub = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;

        #2 rst = 1'b1;
        #1;
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_sum", 32'(bus.sum), 32'd0);
        chk("reset_c_out", 32'(bus.c_out), 32'd0);
        chk("reset_overflow", 32'(bus.overflow), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) apply_vec(vt[i], $sformatf("vec%0d", i));

        // Back-to-back random stream with the sink stalled in cycles 6..9.
        for (int i = 0; i < 10; i++) begin
            ra[i] = W'($urandom); rb[i] = W'($urandom);
            rc[i] = 1'($urandom); rs[i] = 1'($urandom);
        end
        d0 = drained; stall_cnt = 0; idx = 0; cyc = 0;
        @(posedge clk); #1;
        while (cyc < 60 && (idx < 10 || drained - d0 < 10)) begin
            bus.out_ready = !(cyc >= 6 && cyc <= 9);
            if (idx < 10) begin
                bus.in_a = ra[idx]; bus.in_b = rb[idx]; bus.c_in = rc[idx]; bus.sub = rs[idx];
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            took = bus.in_valid & bus.in_ready;
            @(posedge clk); #1;
            if (took) idx++;
            cyc++;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        chk("stream_drained", 32'(drained - d0), 32'd10);
        chk("stream_queue_empty", 32'(expq.size()), 32'd0);
        chk("stream_stall_cycles", 32'(stall_cnt), 32'd4);

        // Reset with three operations in flight and a result on the output.
        for (int i = 0; i < 5; i++) begin
            bus.in_a = W'($urandom); bus.in_b = W'($urandom);
            bus.c_in = 1'($urandom); bus.sub = 1'($urandom);
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        chk("pre_reset_out_valid", 32'(bus.out_valid), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("async_reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_reset_sum", 32'(bus.sum), 32'd0);
        chk("async_reset_c_out", 32'(bus.c_out), 32'd0);
        chk("async_reset_overflow", 32'(bus.overflow), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        chk("no_stale_after_reset", 32'(seen), 32'd0);
        apply_vec(vt[0], "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
